// File: rtl/nios2_oci_dct_pkg.sv
// nios2_oci_dct_pkg: shared state encoding and constants for the OCI debug-trace capture path
package nios2_oci_dct_pkg;
  typedef enum logic [1:0] {CAPTURE, FLUSH, DRAIN, ENDED} dct_state_e;
  localparam logic [63:0] OVF_SAT_ALL = '1;
endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// nios2_oci_dct_fifo: synchronous show-ahead FIFO; push while full is taken when a pop happens in the same cycle
module nios2_oci_dct_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic          wr_en, rd_en;
  assign empty = lvl_q == '0;
  assign full  = lvl_q == (AW+1)'(DEPTH);
  assign level = lvl_q;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem_q[rd_q];
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/nios2_qsys_oci_dct_capture.sv
// nios2_qsys_oci_dct_capture: packs trace entries into frames, buffers them in a FIFO and runs the end-of-test flush/drain
module nios2_qsys_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int ENTRIES = 3,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 4,
  parameter int OVF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       trc_valid,
  input  logic [ENTRY_W-1:0]         trc_data,
  input  logic                       test_ending,
  output logic                       dct_valid,
  input  logic                       dct_ready,
  output logic [ENTRIES*ENTRY_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]           dct_count,
  output logic                       test_has_ended,
  output logic [OVF_W-1:0]           ovf_count,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int FW = ENTRIES*ENTRY_W;
  localparam logic [OVF_W-1:0] OVF_SAT = OVF_SAT_ALL[OVF_W-1:0];
  dct_state_e        state_q, state_d;
  logic [FW-1:0]     data_q, data_d, push_data;
  logic [CNT_W-1:0]  n_q, n_d, push_cnt;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              push, pop, drop, full, empty;
  logic [CNT_W+FW-1:0] rdata;
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    n_d       = n_q;
    push      = 1'b0;
    push_data = data_q;
    push_cnt  = n_q;
    case (state_q)
      CAPTURE: begin
        // the entry is accepted before test_ending moves us on, so a completing entry pushes here
        if (trc_valid) begin
          push_data[int'(n_q)*ENTRY_W +: ENTRY_W] = trc_data;
          push_cnt = n_q + CNT_W'(1);
          push     = push_cnt == CNT_W'(ENTRIES);
          data_d   = push ? '0 : push_data;
          n_d      = push ? '0 : push_cnt;
        end
        if (test_ending) state_d = FLUSH;
      end
      FLUSH: begin
        push    = n_q != '0;
        data_d  = '0;
        n_d     = '0;
        state_d = DRAIN;
      end
      DRAIN:   state_d = empty ? ENDED : DRAIN;
      default: state_d = ENDED;
    endcase
  end
  assign dct_valid = ~empty;
  assign pop       = dct_valid & dct_ready;
  assign drop      = push & full & ~pop;
  assign ovf_d     = (drop && ovf_q != OVF_SAT) ? ovf_q + OVF_W'(1) : ovf_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= CAPTURE;
      data_q  <= '0;
      n_q     <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
    end
  nios2_oci_dct_fifo #(.W(CNT_W+FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({push_cnt, push_data}),
    .pop     (pop),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );
  assign dct_buffer     = dct_valid ? rdata[FW-1:0] : '0;
  assign dct_count      = dct_valid ? rdata[CNT_W+FW-1:FW] : '0;
  assign test_has_ended = state_q == ENDED;
  assign ovf_count      = ovf_q;
endmodule

// File: tb/tb_nios2_qsys_oci_dct_capture.sv
// tb_nios2_qsys_oci_dct_capture: directed checks of frame packing, overflow, flush/drain and reset behaviour
module tb_nios2_qsys_oci_dct_capture;
  logic        clk = 1'b0, reset_n = 1'b0, trc_valid = 1'b0, test_ending = 1'b0, dct_ready = 1'b0;
  logic [9:0]  trc_data = '0;
  logic        dct_valid, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [15:0] ovf_count;
  logic [2:0]  fifo_level;
  int n_chk = 0, n_fail = 0;
  nios2_qsys_oci_dct_capture dut (
    .clk(clk), .reset_n(reset_n), .trc_valid(trc_valid), .trc_data(trc_data),
    .test_ending(test_ending), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
    .ovf_count(ovf_count), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  function automatic logic [29:0] frm(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
    return {c, b, a};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset_n = 1'b0; trc_valid = 1'b0; test_ending = 1'b0; dct_ready = 1'b0;
    #1;
    n_chk++;
    if ({dct_valid, dct_buffer, dct_count, test_has_ended, ovf_count, fifo_level} !== 56'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b buf=%h cnt=%0d end=%b ovf=%0d lvl=%0d, want all 0",
        dct_valid, dct_buffer, dct_count, test_has_ended, ovf_count, fifo_level);
    end
    tick;
    reset_n = 1'b1;
    tick;
    n_chk++;
    if ({dct_valid, test_has_ended, fifo_level} !== 5'd0) begin
      n_fail++; $display("FAIL reset_release: got v=%b end=%b lvl=%0d, want 0", dct_valid, test_has_ended, fifo_level);
    end
  endtask
  task automatic test_frame;
    dct_ready = 1'b1; trc_valid = 1'b1;
    trc_data = 10'h001; tick;
    trc_data = 10'h002; tick;
    trc_data = 10'h003; tick;
    trc_valid = 1'b0;
    n_chk++;
    if (dct_valid !== 1'b1 || dct_buffer !== 30'h00300801 || dct_count !== 4'd3) begin
      n_fail++; $display("FAIL frame_assembly: got v=%b buf=%h cnt=%0d, want 1 00300801 3", dct_valid, dct_buffer, dct_count);
    end
    tick;
    n_chk++;
    if (fifo_level !== 3'd0 || dct_valid !== 1'b0 || dct_buffer !== 30'd0 || dct_count !== 4'd0) begin
      n_fail++; $display("FAIL frame_popped: got lvl=%0d v=%b buf=%h cnt=%0d, want 0 0 0 0", fifo_level, dct_valid, dct_buffer, dct_count);
    end
  endtask
  task automatic test_overflow;
    dct_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      trc_valid = 1'b1; trc_data = 10'(i + 1); tick;
    end
    trc_valid = 1'b0;
    n_chk++;
    if (fifo_level !== 3'd4 || ovf_count !== 16'd1) begin
      n_fail++; $display("FAIL overflow_level: got lvl=%0d ovf=%0d, want 4 1", fifo_level, ovf_count);
    end
    dct_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (dct_valid !== 1'b1 || dct_count !== 4'd3 || dct_buffer !== frm(10'(3*k+1), 10'(3*k+2), 10'(3*k+3))) begin
        n_fail++; $display("FAIL overflow_order[%0d]: got v=%b buf=%h cnt=%0d, want %h", k, dct_valid, dct_buffer, dct_count,
          frm(10'(3*k+1), 10'(3*k+2), 10'(3*k+3)));
      end
      tick;
    end
    dct_ready = 1'b0;
    n_chk++;
    if (fifo_level !== 3'd0 || dct_valid !== 1'b0 || ovf_count !== 16'd1) begin
      n_fail++; $display("FAIL overflow_drained: got lvl=%0d v=%b ovf=%0d, want 0 0 1", fifo_level, dct_valid, ovf_count);
    end
  endtask
  task automatic test_push_full;
    dct_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      trc_valid = 1'b1; trc_data = 10'(10'h200 + i); tick;
    end
    dct_ready = 1'b1; trc_data = 10'h20E; tick;
    trc_valid = 1'b0;
    n_chk++;
    if (fifo_level !== 3'd4 || ovf_count !== 16'd1) begin
      n_fail++; $display("FAIL push_while_full: got lvl=%0d ovf=%0d, want 4 1", fifo_level, ovf_count);
    end
    for (int k = 1; k < 5; k++) begin
      n_chk++;
      if (dct_valid !== 1'b1 || dct_buffer !== frm(10'(10'h200+3*k), 10'(10'h201+3*k), 10'(10'h202+3*k))) begin
        n_fail++; $display("FAIL push_full_order[%0d]: got v=%b buf=%h, want %h", k, dct_valid, dct_buffer,
          frm(10'(10'h200+3*k), 10'(10'h201+3*k), 10'(10'h202+3*k)));
      end
      tick;
    end
    dct_ready = 1'b0;
    n_chk++;
    if (fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL push_full_drained: got lvl=%0d, want 0", fifo_level);
    end
  endtask
  task automatic test_backpressure;
    logic [29:0] q[$];
    logic [29:0] hb;
    logic [3:0]  hc;
    logic        held = 1'b0;
    int          sent = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      dct_ready = (cyc >= 50) ? 1'b1 : 1'($urandom_range(0, 1));
      trc_valid = sent < 12;
      trc_data  = 10'(10'h100 + sent);
      if (held) begin
        n_chk++;
        if (dct_valid !== 1'b1 || dct_buffer !== hb || dct_count !== hc) begin
          n_fail++; $display("FAIL bp_stable[%0d]: got v=%b buf=%h cnt=%0d, want 1 %h %0d", cyc, dct_valid, dct_buffer, dct_count, hb, hc);
        end
      end
      if (dct_valid && dct_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra[%0d]: got buf=%h, want no frame", cyc, dct_buffer);
        end else begin
          if (dct_buffer !== q[0] || dct_count !== 4'd3) begin
            n_fail++; $display("FAIL bp_pop[%0d]: got buf=%h cnt=%0d, want %h 3", cyc, dct_buffer, dct_count, q[0]);
          end
          void'(q.pop_front());
        end
      end
      held = dct_valid && !dct_ready;
      hb = dct_buffer; hc = dct_count;
      if (trc_valid) begin
        sent++;
        if (sent % 3 == 0) q.push_back(frm(10'(10'h100+sent-3), 10'(10'h100+sent-2), 10'(10'h100+sent-1)));
      end
      tick;
    end
    trc_valid = 1'b0; dct_ready = 1'b0;
    n_chk++;
    if (q.size() != 0 || fifo_level !== 3'd0 || ovf_count !== 16'd1) begin
      n_fail++; $display("FAIL bp_lost: got left=%0d lvl=%0d ovf=%0d, want 0 0 1", q.size(), fifo_level, ovf_count);
    end
  endtask
  task automatic test_reset_drain;
    dct_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      trc_valid = 1'b1; trc_data = 10'(10'h050 + i); tick;
    end
    trc_valid = 1'b0; test_ending = 1'b1;
    tick; tick;
    test_ending = 1'b0;
    tick;
    n_chk++;
    if (fifo_level !== 3'd2 || test_has_ended !== 1'b0 || dct_valid !== 1'b1) begin
      n_fail++; $display("FAIL drain_hold: got lvl=%0d end=%b v=%b, want 2 0 1", fifo_level, test_has_ended, dct_valid);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({dct_valid, dct_buffer, dct_count, test_has_ended, ovf_count, fifo_level} !== 56'd0) begin
      n_fail++; $display("FAIL drain_reset: got v=%b buf=%h cnt=%0d end=%b ovf=%0d lvl=%0d, want all 0",
        dct_valid, dct_buffer, dct_count, test_has_ended, ovf_count, fifo_level);
    end
    tick;
    reset_n = 1'b1;
    dct_ready = 1'b1; trc_valid = 1'b1;
    trc_data = 10'h011; tick;
    trc_data = 10'h022; tick;
    trc_data = 10'h033; tick;
    trc_valid = 1'b0;
    n_chk++;
    if (dct_valid !== 1'b1 || dct_buffer !== frm(10'h011, 10'h022, 10'h033) || dct_count !== 4'd3) begin
      n_fail++; $display("FAIL post_reset_capture: got v=%b buf=%h cnt=%0d, want 1 %h 3", dct_valid, dct_buffer, dct_count,
        frm(10'h011, 10'h022, 10'h033));
    end
    tick;
    dct_ready = 1'b0;
  endtask
  task automatic test_flush;
    dct_ready = 1'b0; trc_valid = 1'b1;
    trc_data = 10'h3FF; tick;
    trc_data = 10'h155; tick;
    trc_valid = 1'b0; test_ending = 1'b1;
    tick; tick;
    n_chk++;
    if (dct_valid !== 1'b1 || dct_buffer !== 30'h000557FF || dct_count !== 4'd2 || test_has_ended !== 1'b0) begin
      n_fail++; $display("FAIL flush_partial: got v=%b buf=%h cnt=%0d end=%b, want 1 000557ff 2 0", dct_valid, dct_buffer, dct_count, test_has_ended);
    end
    tick;
    n_chk++;
    if (dct_buffer !== 30'h000557FF || test_has_ended !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait: got buf=%h end=%b, want 000557ff 0", dct_buffer, test_has_ended);
    end
    dct_ready = 1'b1; tick;
    n_chk++;
    if (fifo_level !== 3'd0 || test_has_ended !== 1'b0) begin
      n_fail++; $display("FAIL flush_popped: got lvl=%0d end=%b, want 0 0", fifo_level, test_has_ended);
    end
    tick;
    n_chk++;
    if (test_has_ended !== 1'b1) begin
      n_fail++; $display("FAIL flush_ended: got end=%b, want 1", test_has_ended);
    end
    test_ending = 1'b0; trc_valid = 1'b1; trc_data = 10'h005;
    tick; tick;
    trc_valid = 1'b0;
    n_chk++;
    if (test_has_ended !== 1'b1 || fifo_level !== 3'd0 || dct_valid !== 1'b0) begin
      n_fail++; $display("FAIL ended_sticky: got end=%b lvl=%0d v=%b, want 1 0 0", test_has_ended, fifo_level, dct_valid);
    end
  endtask
  task automatic test_simul;
    dct_ready = 1'b0; trc_valid = 1'b1;
    trc_data = 10'h00A; tick;
    trc_data = 10'h00B; tick;
    trc_data = 10'h00C; test_ending = 1'b1; tick;
    trc_valid = 1'b0;
    tick; tick;
    n_chk++;
    if (fifo_level !== 3'd1 || dct_buffer !== frm(10'h00A, 10'h00B, 10'h00C) || dct_count !== 4'd3) begin
      n_fail++; $display("FAIL simul_one_frame: got lvl=%0d buf=%h cnt=%0d, want 1 %h 3", fifo_level, dct_buffer, dct_count,
        frm(10'h00A, 10'h00B, 10'h00C));
    end
    dct_ready = 1'b1; tick; tick;
    n_chk++;
    if (test_has_ended !== 1'b1 || dct_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL simul_ended: got end=%b v=%b lvl=%0d, want 1 0 0", test_has_ended, dct_valid, fifo_level);
    end
    test_ending = 1'b0; dct_ready = 1'b0;
  endtask
  initial begin
    test_reset;
    test_frame;
    test_overflow;
    test_push_full;
    test_backpressure;
    test_reset_drain;
    test_flush;
    test_reset;
    test_simul;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nios2_qsys_oci_dct_capture.md
Name: nios2_qsys_oci_dct_capture

Overview:
Parametrised debug-trace (DCT) capture block for the Nios II OCI debug path.
- Packs single trace entries into multi-entry frames and buffers frames in a small FIFO.
- Presents frames as a dct_buffer / dct_count pair with a valid/ready handshake.
- Implements the end-of-test sequence: flush the partial frame, drain the FIFO, then raise test_has_ended.

Parameters:
ENTRY_W, 10, width of one trace entry
ENTRIES, 3, entries per frame; dct_buffer width = ENTRIES*ENTRY_W (default 30)
CNT_W, 4, width of dct_count; must satisfy CNT_W >= clog2(ENTRIES+1)
DEPTH, 4, frame FIFO depth; power of 2, >= 2
OVF_W, 16, width of the saturating drop counter

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
trc_valid  in  1  trace entry present this cycle; no backpressure
trc_data  in  ENTRY_W  trace entry
test_ending  in  1  level; request end-of-test flush
dct_valid  out  1  FIFO head frame valid
dct_ready  in  1  consumer accepts head frame
dct_buffer  out  ENTRIES*ENTRY_W  head frame; entry 0 in LSBs
dct_count  out  CNT_W  valid entries in head frame (1..ENTRIES)
test_has_ended  out  1  flush and drain complete; sticky until reset
ovf_count  out  OVF_W  frames dropped because the FIFO was full; saturating
fifo_level  out  clog2(DEPTH)+1  frames held

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, packer empty, FIFO empty, state CAPTURE.
- States:
  - CAPTURE -> FLUSH when test_ending=1.
  - FLUSH -> DRAIN unconditionally, after 1 cycle.
  - DRAIN -> ENDED when the FIFO is empty.
  - ENDED is held until reset.
- Packer (CAPTURE only):
  - trc_valid writes trc_data into slot n at bits [n*ENTRY_W +: ENTRY_W]; n++.
  - When the write fills slot ENTRIES-1, the completed frame (count=ENTRIES) is pushed in that same cycle and the packer clears to n=0 with all slots zero.
- trc_valid in FLUSH, DRAIN or ENDED is ignored and is not counted as a drop.
- test_ending in the same cycle as trc_valid in CAPTURE: the entry is accepted first.
  - If that entry completes a frame, the full frame is pushed in CAPTURE and FLUSH then has n=0, so FLUSH pushes nothing.
- FLUSH: if n>0, push the partial frame with count=n; unused slots are zero. If n=0, no push. Packer clears.
- Push rule: accepted when FIFO not full, or when full and a pop happens in the same cycle.
  - Otherwise the frame is dropped and ovf_count increments, saturating at all-ones.
  - The packer clears in either case.
- FIFO is show-ahead:
  - A frame pushed in cycle N, into an empty FIFO, appears with dct_valid=1 in cycle N+1.
  - Pop occurs on dct_valid & dct_ready.
  - dct_buffer and dct_count must be stable while dct_valid=1 and dct_ready=0.
- dct_valid=0 forces dct_buffer=0 and dct_count=0.
- fifo_level counts frames held, range 0..DEPTH. A simultaneous push and pop leaves it unchanged.
- test_has_ended=1 from the first cycle in ENDED. test_ending deasserting afterwards has no effect.
- Reset mid-operation: in-flight frames are discarded and ovf_count clears.

Decomposition:
- Package nios2_oci_dct_pkg: state enum (CAPTURE, FLUSH, DRAIN, ENDED) and OVF saturation constant.
- Sub-module nios2_oci_dct_fifo: synchronous show-ahead FIFO, parametrised width and depth.
  - Outputs: full, empty, level.
  - Push-when-full is allowed when a pop occurs in the same cycle.

Test Plan:
- Frame assembly (defaults): entries 0x001, 0x002, 0x003 on 3 consecutive cycles, dct_ready=1 -> one cycle after the third entry, dct_valid=1 with dct_buffer=0x00300801 and dct_count=3; fifo_level returns to 0.
- Overflow: dct_ready=0, 15 entries (5 frames) -> fifo_level=4, ovf_count=1, head frame equals the first frame; raise dct_ready -> 4 frames pop in order.
- Flush: 2 entries 0x3FF, 0x155, then test_ending -> partial frame dct_buffer=0x000557FF, dct_count=2; test_has_ended rises once the FIFO is empty.
- Simultaneous events, part 1: test_ending on the cycle of the 3rd entry -> exactly one frame with count=3 and no extra frame.
- Simultaneous events, part 2: push while full with dct_ready=1 -> no drop.
- Backpressure stability: dct_ready toggled randomly -> dct_buffer and dct_count constant while dct_valid=1 and dct_ready=0; no frame lost or duplicated.
- Reset mid-drain: reset_n pulsed low while in DRAIN with 2 frames held -> all outputs 0 immediately; state CAPTURE; new capture works normally.
